// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data width, parity and stop-bit configuration.
// A word is accepted on tx_valid & tx_ready, and its config is latched with it for the whole frame.
//
// state    | meaning
// S_IDLE   | line high, ready for a word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only if enabled)
// S_STOP   | one or two stop bits (high)
module uart_tx_cfg #(
  parameter int DATA_BITS_MAX = 9,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     tick,
  input  logic [DATA_BITS_MAX-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic                     tx,
  output logic                     tx_done
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            tick_cnt, tick_cnt_nxt;
  logic [3:0]               bits_left, bits_left_nxt;
  logic [DATA_BITS_MAX-1:0] shift_reg, shift_nxt;
  logic                     par_en, par_en_nxt;
  logic                     par_bit, par_bit_nxt;
  logic                     stop2, stop2_nxt;
  logic                     stop_left, stop_left_nxt;
  logic                     tx_nxt, done_nxt;
  logic [3:0]               n_clamped;
  logic [DATA_BITS_MAX-1:0] data_mask;
  logic                     bit_end;

  always_comb begin
    n_clamped = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      n_clamped = 4'd5;
    else if (cfg_data_bits > 4'(DATA_BITS_MAX))
      n_clamped = 4'(DATA_BITS_MAX);
    data_mask = '0;
    for (int i = 0; i < DATA_BITS_MAX; i++)
      data_mask[i] = (i < int'(n_clamped));
  end

  // Bit timer is a down-counter; a bit ends on the tick that finds it at zero.
  assign bit_end  = tick && (tick_cnt == '0);
  assign tx_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bits_left <= '0;
      shift_reg <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      stop_left <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bits_left <= bits_left_nxt;
      shift_reg <= shift_nxt;
      par_en    <= par_en_nxt;
      par_bit   <= par_bit_nxt;
      stop2     <= stop2_nxt;
      stop_left <= stop_left_nxt;
      tx        <= tx_nxt;
      tx_done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bits_left_nxt = bits_left;
    shift_nxt     = shift_reg;
    par_en_nxt    = par_en;
    par_bit_nxt   = par_bit;
    stop2_nxt     = stop2;
    stop_left_nxt = stop_left;
    tx_nxt        = 1'b1;
    done_nxt      = 1'b0;

    if (state != S_IDLE && tick)
      tick_cnt_nxt = bit_end ? TC_LOAD : tick_cnt - CW'(1);

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_nxt     = tx_data;
          bits_left_nxt = n_clamped - 4'd1;
          par_en_nxt    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_bit_nxt   = (^(tx_data & data_mask)) ^ (cfg_parity == 2'b10);
          stop2_nxt     = cfg_stop2;
          stop_left_nxt = 1'b0;
          tick_cnt_nxt  = TC_LOAD;
          state_nxt     = S_START;
          tx_nxt        = 1'b0;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = S_DATA;
          tx_nxt    = shift_reg[0];
        end
      end
      S_DATA: begin
        tx_nxt = shift_reg[0];
        if (bit_end) begin
          if (bits_left == 4'd0) begin
            if (par_en) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt     = S_STOP;
              tx_nxt        = 1'b1;
              stop_left_nxt = stop2;
            end
          end else begin
            shift_nxt     = shift_reg >> 1;
            bits_left_nxt = bits_left - 4'd1;
            tx_nxt        = shift_reg[1];
          end
        end
      end
      S_PARITY: begin
        tx_nxt = par_bit;
        if (bit_end) begin
          state_nxt     = S_STOP;
          tx_nxt        = 1'b1;
          stop_left_nxt = stop2;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_left) begin
            stop_left_nxt = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized and directed bench for uart_tx_cfg; expected frames come from a bit-list model
// and are checked by a monitor that samples the line mid-bit by counting ticks.
module tb_uart_tx_cfg;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       tick;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       tx_done;

  uart_tx_cfg #(.DATA_BITS_MAX(9), .OVERSAMPLE(OS)) dut (
    .clk(clk), .arst_n(arst_n), .tick(tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx(tx), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     tick_mode = 1;
  int     b2b_count = 0;
  bit     in_frame = 1'b0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected line sequence: start, N data bits LSB first, optional parity, stop bit(s).
  function automatic frame_t model(input logic [8:0] d, input int nb, input logic [1:0] par,
                                   input logic st2);
    frame_t f;
    int     n;
    logic   p;
    n = (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.len = 1;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[f.len] = d[i];
      p = p ^ d[i];
      f.len = f.len + 1;
    end
    if (par == 2'b01 || par == 2'b10) begin
      f.bits[f.len] = (par == 2'b10) ? ~p : p;
      f.len = f.len + 1;
    end
    f.bits[f.len] = 1'b1;
    f.len = f.len + 1;
    if (st2) begin
      f.bits[f.len] = 1'b1;
      f.len = f.len + 1;
    end
    return f;
  endfunction

  initial begin : tick_gen
    int div = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_mode == 0) begin
        tick = 1'($urandom_range(0, 1));
      end else begin
        div = (div + 1) % tick_mode;
        tick = (div == 0);
      end
    end
  end

  initial begin : monitor
    frame_t cur;
    int     c;
    int     total;
    c = 0;
    total = 0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        in_frame = 1'b0;
        exp_q.delete();
        continue;
      end
      if (!in_frame) begin
        chk("idle_no_done", tx_done, 1'b0);
        if (tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_start: got tx=0 expected no frame at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            c = 0;
            total = cur.len * OS;
          end
        end
      end
      if (in_frame) begin
        if (c == total) begin
          chk("done_pulse", tx_done, 1'b1);
          chk("done_ready", tx_ready, 1'b1);
          chk("done_line_high", tx, 1'b1);
          in_frame = 1'b0;
        end else begin
          chk("no_early_done", tx_done, 1'b0);
          if (tick && (c % OS == OS / 2))
            chk($sformatf("bit%0d", c / OS), tx, cur.bits[c / OS]);
          if (tick) c++;
        end
      end
    end
  end

  task automatic drive_garbage();
    tx_valid      = 1'b1;
    tx_data       = 9'($urandom);
    cfg_data_bits = 4'($urandom);
    cfg_parity    = 2'($urandom);
    cfg_stop2     = 1'($urandom);
  endtask

  // Hold keeps tx_valid high with junk while busy, so the next call can accept in the tx_done cycle.
  task automatic send(input logic [8:0] d, input int nb, input logic [1:0] par,
                      input logic st2, input bit hold);
    int   guard;
    logic saw_done;
    bit   ok;
    guard = 0;
    ok = 1'b0;
    saw_done = 1'b0;
    while (guard < 5000) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_valid      = 1'b1;
        tx_data       = d;
        cfg_data_bits = 4'(nb);
        cfg_parity    = par;
        cfg_stop2     = st2;
        saw_done      = tx_done;
        ok = 1'b1;
        break;
      end
      drive_garbage();
      guard++;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got tx_ready=0 expected 1 within 5000 clks");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(d, nb, par, st2));
    if (saw_done) b2b_count++;
    @(negedge clk);
    chk("start_latency", tx, 1'b0);
    chk("busy_not_ready", tx_ready, 1'b0);
    if (hold) drive_garbage();
    else tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || in_frame) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    arst_n        = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", tx_ready, 1'b1);
    chk("reset_done", tx_done, 1'b0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", tx, 1'b1);

    tick_mode = 1;
    send(9'h0A5, 8, 2'b00, 1'b0, 1'b0);
    send(9'h041, 7, 2'b01, 1'b1, 1'b0);
    send(9'h1FF, 9, 2'b10, 1'b0, 1'b0);
    send(9'h1FF, 9, 2'b01, 1'b0, 1'b0);
    send(9'h0FF, 3, 2'b00, 1'b0, 1'b0);
    send(9'h12C, 15, 2'b10, 1'b1, 1'b0);
    send(9'h0B3, 6, 2'b11, 1'b0, 1'b0);
    wait_drain();

    tick_mode = 4;
    b2b_count = 0;
    send(9'h0C3, 8, 2'b00, 1'b0, 1'b1);
    send(9'h05A, 7, 2'b01, 1'b1, 1'b0);
    wait_drain();
    chk("b2b_accept_in_done_cycle", (b2b_count != 0), 1'b1);

    tick_mode = 0;
    for (int k = 0; k < 20; k++)
      send(9'($urandom), int'($urandom_range(0, 15)), 2'($urandom), 1'($urandom),
           (k != 19) && ($urandom_range(0, 1) == 1));
    wait_drain();

    tick_mode = 1;
    send(9'h0A5, 8, 2'b00, 1'b0, 1'b0);
    repeat (72) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", tx, 1'b1);
    chk("midframe_rst_done", tx_done, 1'b0);
    chk("midframe_rst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b1;
    send(9'h0A5, 8, 2'b00, 1'b0, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
